// File: rtl/iq_lane_decimator.sv
// Sums 3 I and 3 Q lanes per beat, boxcar-integrates DEC beats, scales/saturates, queues in a FIFO.
// Latency: the edge taking the DEC-th beat is edge 0; the result is at the FIFO head after edge 3.
// Backpressure: the input is never stalled; results arriving at a full FIFO are dropped and counted.
module iq_lane_decimator #(
    parameter int DEC        = 4,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [47:0] s_i_data,
    input  logic [47:0] s_q_data,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    input  logic        clr_ovf,
    output logic        ovf,
    output logic [7:0]  drop_cnt
);
    localparam int CW   = $clog2(DEC);
    localparam int AW   = 18 + CW;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

    function automatic logic signed [17:0] ext18(input logic [15:0] v);
        return {{2{v[15]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] ext_acc(input logic signed [17:0] v);
        return {{CW{v[17]}}, v};
    endfunction

    function automatic logic [15:0] sat16(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> SHIFT;
        if (s > SAT_MAX)
            sat16 = 16'h7fff;
        else if (s < SAT_MIN)
            sat16 = 16'h8000;
        else
            sat16 = s[15:0];
    endfunction

    logic signed [17:0]   sum_i, sum_q;
    logic                 s1_vld;
    logic signed [AW-1:0] acc_i, acc_q;
    logic [CW-1:0]        beat_cnt;
    logic                 fin_vld;
    logic [31:0]          res_dat;
    logic                 res_vld;

    // Stage 1: lane sums; three 16-bit lanes always fit in 18 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            sum_i  <= '0;
            sum_q  <= '0;
        end else begin
            s1_vld <= s_valid;
            if (s_valid) begin
                sum_i <= ext18(s_i_data[15:0]) + ext18(s_i_data[31:16]) + ext18(s_i_data[47:32]);
                sum_q <= ext18(s_q_data[15:0]) + ext18(s_q_data[31:16]) + ext18(s_q_data[47:32]);
            end
        end
    end

    // Stage 2: block integrator; idle cycles simply hold the partial sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i    <= '0;
            acc_q    <= '0;
            beat_cnt <= '0;
            fin_vld  <= 1'b0;
        end else begin
            fin_vld <= s1_vld && (beat_cnt == CW'(DEC - 1));
            if (s1_vld) begin
                acc_i    <= (beat_cnt == '0) ? ext_acc(sum_i) : acc_i + ext_acc(sum_i);
                acc_q    <= (beat_cnt == '0) ? ext_acc(sum_q) : acc_q + ext_acc(sum_q);
                beat_cnt <= (beat_cnt == CW'(DEC - 1)) ? '0 : beat_cnt + CW'(1);
            end
        end
    end

    // Stage 3: scale and saturate the finished block into a {Q,I} word.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_dat <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= fin_vld;
            if (fin_vld)
                res_dat <= {sat16(acc_q), sat16(acc_i)};
        end
    end

    logic [31:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            full, do_pop, do_push, drop;

    assign full     = (count == CNTW'(FIFO_DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign do_pop   = m_tvalid && m_tready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push  = res_vld && (!full || do_pop);
    assign drop     = res_vld && full && !do_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++)
                mem[k] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= res_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CNTW'(1);
            else if (!do_push && do_pop)
                count <= count - CNTW'(1);
            // A drop coinciding with a clear leaves exactly that one drop recorded.
            if (drop) begin
                ovf      <= 1'b1;
                drop_cnt <= clr_ovf ? 8'd1 : ((drop_cnt == 8'hff) ? 8'hff : drop_cnt + 8'd1);
            end else if (clr_ovf) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_iq_lane_decimator.sv
// Randomized bench for iq_lane_decimator against a block-sum reference model.
module tb_iq_lane_decimator;
    localparam int DEC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [47:0] s_i_data, s_q_data;
    logic        m_tready;
    logic        clr_ovf;
    logic        m_tvalid, m_tvalid1;
    logic [31:0] m_tdata, m_tdata1;
    logic        ovf, ovf1;
    logic [7:0]  drop_cnt, drop_cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] exp0[$], exp1[$], got0[$], got1[$];
    int mi, mq, mcnt;

    always #5 clk = ~clk;

    iq_lane_decimator dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_i_data(s_i_data), .s_q_data(s_q_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .clr_ovf(clr_ovf), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    iq_lane_decimator #(.SHIFT(0)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_i_data(s_i_data), .s_q_data(s_q_data),
        .m_tvalid(m_tvalid1), .m_tready(m_tready), .m_tdata(m_tdata1),
        .clr_ovf(clr_ovf), .ovf(ovf1), .drop_cnt(drop_cnt1)
    );

    // Record every accepted output word, sampled just before the accepting edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst && m_tvalid && m_tready) got0.push_back(m_tdata);
        if (!rst && m_tvalid1 && m_tready) got1.push_back(m_tdata1);
    end

    function automatic int lane_sum(input logic [47:0] d);
        return int'($signed(d[15:0])) + int'($signed(d[31:16])) + int'($signed(d[47:32]));
    endfunction

    function automatic logic [15:0] scale(input int acc, input int sh);
        int v;
        v = acc >>> sh;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic send_beat(input logic [47:0] i, input logic [47:0] q);
        @(negedge clk);
        s_valid  = 1'b1;
        s_i_data = i;
        s_q_data = q;
        mi += lane_sum(i);
        mq += lane_sum(q);
        mcnt++;
        if (mcnt == DEC) begin
            exp0.push_back({scale(mq, 4), scale(mi, 4)});
            exp1.push_back({scale(mq, 0), scale(mi, 0)});
            mi = 0; mq = 0; mcnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mi = 0; mq = 0; mcnt = 0;
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
        tests_run++;
        if (m_tdata !== 32'h0) begin tests_failed++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b want 0", ovf); end
        tests_run++;
        if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    endtask

    task automatic test_basic_latency();
        do_reset();
        m_tready = 1'b1;
        repeat (DEC) send_beat({3{16'd1000}}, {3{16'd1000}});
        @(negedge clk); s_valid = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            @(negedge clk);
            tests_run++;
            if (m_tvalid !== 1'b0) begin
                tests_failed++; $display("FAIL latency_early edge%0d tvalid got %b want 0", e, m_tvalid);
            end
        end
        @(negedge clk);
        tests_run++;
        if (m_tvalid !== 1'b1 || m_tdata !== exp0[0]) begin
            tests_failed++; $display("FAIL latency_edge3 tvalid=%b data=%h want 1/%h", m_tvalid, m_tdata, exp0[0]);
        end
        idle(4);
        tests_run++;
        if (got0.size() != 1 || got0[0] !== exp0[0]) begin
            tests_failed++; $display("FAIL basic_out count=%0d want 1 / %h", got0.size(), exp0[0]);
        end
    endtask

    task automatic test_two_outputs();
        do_reset();
        m_tready = 1'b1;
        repeat (2 * DEC) send_beat({16'd200, 16'd100, 16'd0}, {3{16'hfc18}});
        idle(12);
        tests_run++;
        if (got0.size() != 2) begin tests_failed++; $display("FAIL two_out_count got %0d want 2", got0.size()); end
        for (int k = 0; k < 2 && k < got0.size(); k++) begin
            tests_run++;
            if (got0[k] !== exp0[k]) begin
                tests_failed++; $display("FAIL two_out_data[%0d] got %h want %h", k, got0[k], exp0[k]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        m_tready = 1'b1;
        repeat (DEC) send_beat({3{16'h7fff}}, {3{16'h8000}});
        idle(12);
        tests_run++;
        if (got1.size() != 1 || got1[0] !== exp1[0]) begin
            tests_failed++; $display("FAIL sat_shift0 count=%0d want 1 / %h", got1.size(), exp1[0]);
        end
        tests_run++;
        if (got0.size() != 1 || got0[0] !== exp0[0]) begin
            tests_failed++; $display("FAIL sat_shift4 count=%0d want 1 / %h", got0.size(), exp0[0]);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        m_tready = 1'b1;
        repeat (DEC) begin
            send_beat({3{16'd1000}}, {3{16'd1000}});
            idle(1);
        end
        repeat (DEC) begin
            send_beat(rnd48(), rnd48());
            idle(1);
        end
        idle(12);
        tests_run++;
        if (got0.size() != 2) begin tests_failed++; $display("FAIL gaps_count got %0d want 2", got0.size()); end
        for (int k = 0; k < 2 && k < got0.size(); k++) begin
            tests_run++;
            if (got0[k] !== exp0[k]) begin
                tests_failed++; $display("FAIL gaps_data[%0d] got %h want %h", k, got0[k], exp0[k]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int b = 0; b < 12 * DEC; b++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            send_beat(rnd48(), rnd48());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        m_tready = 1'b1;
        idle(16);
        tests_run++;
        if (got0.size() != exp0.size()) begin
            tests_failed++; $display("FAIL rand_count got %0d want %0d", got0.size(), exp0.size());
        end
        for (int k = 0; k < exp0.size() && k < got0.size(); k++) begin
            tests_run++;
            if (got0[k] !== exp0[k]) begin
                tests_failed++; $display("FAIL rand_data[%0d] got %h want %h", k, got0[k], exp0[k]);
            end
        end
        tests_run++;
        if (got1.size() != exp1.size()) begin
            tests_failed++; $display("FAIL rand_sh0_count got %0d want %0d", got1.size(), exp1.size());
        end
        for (int k = 0; k < exp1.size() && k < got1.size(); k++) begin
            tests_run++;
            if (got1[k] !== exp1[k]) begin
                tests_failed++; $display("FAIL rand_sh0_data[%0d] got %h want %h", k, got1[k], exp1[k]);
            end
        end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL rand_no_ovf got %b want 0", ovf); end
    endtask

    task automatic test_full_and_clear();
        do_reset();
        m_tready = 1'b0;
        repeat (5 * DEC) send_beat(rnd48(), rnd48());
        idle(8);
        tests_run++;
        if (m_tvalid !== 1'b1 || ovf !== 1'b1 || drop_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL full_drop tvalid=%b ovf=%b drop_cnt=%0d want 1/1/1", m_tvalid, ovf, drop_cnt);
        end
        // Sixth block is dropped on the very cycle clr_ovf pulses.
        repeat (DEC) send_beat(rnd48(), rnd48());
        @(negedge clk); s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        tests_run++;
        if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
            tests_failed++; $display("FAIL clr_vs_drop ovf=%b drop_cnt=%0d want 1/1", ovf, drop_cnt);
        end
        m_tready = 1'b1;
        idle(10);
        tests_run++;
        if (got0.size() != 4) begin tests_failed++; $display("FAIL drain_count got %0d want 4", got0.size()); end
        for (int k = 0; k < 4 && k < got0.size(); k++) begin
            tests_run++;
            if (got0[k] !== exp0[k]) begin
                tests_failed++; $display("FAIL drain_data[%0d] got %h want %h", k, got0[k], exp0[k]);
            end
        end
        tests_run++;
        if (m_tvalid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty tvalid got %b want 0", m_tvalid); end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        tests_run++;
        if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
            tests_failed++; $display("FAIL clr_ovf ovf=%b drop_cnt=%0d want 0/0", ovf, drop_cnt);
        end
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        m_tready = 1'b1;
        repeat (2) send_beat({3{16'd1000}}, {3{16'd1000}});
        do_reset();
        repeat (DEC) send_beat({3{16'd1000}}, {3{16'd1000}});
        idle(12);
        tests_run++;
        if (got0.size() != 1) begin tests_failed++; $display("FAIL midrst_count got %0d want 1", got0.size()); end
        tests_run++;
        if (got0.size() > 0 && got0[0] !== exp0[0]) begin
            tests_failed++; $display("FAIL midrst_data got %h want %h", got0[0], exp0[0]);
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_i_data = '0; s_q_data = '0;
        m_tready = 1'b0; clr_ovf = 1'b0;
        mi = 0; mq = 0; mcnt = 0;
        test_reset();
        test_basic_latency();
        test_two_outputs();
        test_saturation();
        test_gaps();
        test_random();
        test_full_and_clear();
        test_reset_mid_block();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
